goldschmidt_sequencer: RTL and testbench

//  Iterative Goldschmidt divider control/operand stage for the shared CSA array multiplier datapath.

---
 rtl/goldschmidt_sequencer_if.sv | 27 ++
 rtl/goldschmidt_sequencer.sv | 125 ++++++++++++
 tb/tb_goldschmidt_sequencer.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/goldschmidt_sequencer_if.sv
// Handshake and multiplier-operand bundle between the Goldschmidt sequencer and its neighbours.
// Both sides use valid/ready: a transfer happens on a rising clk edge where valid & ready are high.
// A source holds valid and its payload stable until that edge.
interface goldschmidt_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] N;
  logic [31:0] D;
  logic [31:0] IA;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [63:0] mul_p;
  logic [31:0] q;
  logic        out_valid;
  logic        out_ready;
  logic        ovf;

  modport slave (
    input  in_valid, N, D, IA, mul_p, out_ready,
    output in_ready, mul_a, mul_b, q, out_valid, ovf
  );

  modport master (
    output in_valid, N, D, IA, mul_p, out_ready,
    input  in_ready, mul_a, mul_b, q, out_valid, ovf
  );
endinterface

// File: rtl/goldschmidt_sequencer.sv
// Goldschmidt divider sequencer: feeds the shared multiplier with Nr*K and Dr*K pairs and
// refines K = 2 - Dr until ITER iterations past the initial IA scaling step are done.
module goldschmidt_sequencer #(
  parameter int ITER    = 2,
  parameter int MUL_LAT = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  goldschmidt_sequencer_if.slave        bus,
  output logic [1:0]                    dbg_state
);

  typedef enum logic [1:0] {IDLE, MUL_N, MUL_D, DONE} state_t;

  localparam int              WW      = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [WW-1:0]   W_LAST  = WW'(MUL_LAT - 1);
  localparam logic [WW-1:0]   W_ONE   = WW'(1);
  localparam logic [2:0]      IT_LAST = 3'(ITER);

  state_t        state, state_nx;
  logic [31:0]   nr, dr, k, q_r, mul_a_r, mul_b_r;
  logic [2:0]    it;
  logic [WW-1:0] wcnt;
  logic          ovf_r;
  logic          accept, capture;
  logic [31:0]   p_trunc, k_nx;
  logic          p_ovf;
  logic          unused_p;

  // Q4.60 product back to Q2.30; the top two bits would not fit and only raise ovf.
  assign p_trunc  = bus.mul_p[61:30];
  assign p_ovf    = |bus.mul_p[63:62];
  assign k_nx     = 32'h8000_0000 - p_trunc;
  assign unused_p = ^bus.mul_p[29:0];

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    capture  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          accept   = 1'b1;
          state_nx = MUL_N;
        end
      end
      MUL_N: begin
        if (wcnt == W_LAST) begin
          capture  = 1'b1;
          state_nx = MUL_D;
        end
      end
      MUL_D: begin
        if (wcnt == W_LAST) begin
          capture  = 1'b1;
          state_nx = (it == IT_LAST) ? DONE : MUL_N;
        end
      end
      DONE: begin
        if (bus.out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // mul_a/mul_b are loaded one step ahead so they already hold the next pair when the
  // state changes, and simply keep their value in IDLE and DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      nr      <= '0;
      dr      <= '0;
      k       <= '0;
      it      <= '0;
      wcnt    <= '0;
      ovf_r   <= 1'b0;
      q_r     <= '0;
      mul_a_r <= '0;
      mul_b_r <= '0;
    end else if (accept) begin
      nr      <= bus.N;
      dr      <= bus.D;
      k       <= bus.IA;
      it      <= '0;
      wcnt    <= '0;
      ovf_r   <= 1'b0;
      mul_a_r <= bus.N;
      mul_b_r <= bus.IA;
    end else if (state == MUL_N || state == MUL_D) begin
      if (capture) begin
        wcnt  <= '0;
        ovf_r <= ovf_r | p_ovf;
        if (state == MUL_N) begin
          nr      <= p_trunc;
          mul_a_r <= dr;
        end else begin
          dr <= p_trunc;
          k  <= k_nx;
          if (it == IT_LAST) begin
            q_r <= nr;
          end else begin
            it      <= it + 3'd1;
            mul_a_r <= nr;
            mul_b_r <= k_nx;
          end
        end
      end else begin
        wcnt <= wcnt + W_ONE;
      end
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.q         = q_r;
  assign bus.mul_a     = mul_a_r;
  assign bus.mul_b     = mul_b_r;
  assign bus.ovf       = ovf_r;
  assign dbg_state     = state;

endmodule

// File: tb/tb_goldschmidt_sequencer.sv
// Bench for goldschmidt_sequencer: two instances (ITER=2/MUL_LAT=1 and ITER=1/MUL_LAT=3),
// each with a behavioural multiplier, driven by directed operations against an arithmetic model.
module tb_goldschmidt_sequencer;

  logic clk;
  logic reset;
  int   tests_run = 0;
  int   tests_failed = 0;

  goldschmidt_sequencer_if bus_a ();
  goldschmidt_sequencer_if bus_b ();
  logic [1:0] dbg_a, dbg_b;

  goldschmidt_sequencer #(.ITER(2), .MUL_LAT(1)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a), .dbg_state(dbg_a)
  );
  goldschmidt_sequencer #(.ITER(1), .MUL_LAT(3)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b), .dbg_state(dbg_b)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bench-side signal arrays (index 0 = dut_a, 1 = dut_b) ----------------
  logic        in_valid_d [2];
  logic        out_ready_d[2];
  logic [31:0] n_d [2], d_d [2], ia_d [2];
  logic        in_ready_o [2], out_valid_o[2], ovf_o[2];
  logic [31:0] q_o [2], mul_a_o[2], mul_b_o[2];

  assign bus_a.in_valid  = in_valid_d[0];
  assign bus_a.out_ready = out_ready_d[0];
  assign bus_a.N         = n_d[0];
  assign bus_a.D         = d_d[0];
  assign bus_a.IA        = ia_d[0];
  assign bus_b.in_valid  = in_valid_d[1];
  assign bus_b.out_ready = out_ready_d[1];
  assign bus_b.N         = n_d[1];
  assign bus_b.D         = d_d[1];
  assign bus_b.IA        = ia_d[1];

  assign in_ready_o[0]  = bus_a.in_ready;
  assign out_valid_o[0] = bus_a.out_valid;
  assign ovf_o[0]       = bus_a.ovf;
  assign q_o[0]         = bus_a.q;
  assign mul_a_o[0]     = bus_a.mul_a;
  assign mul_b_o[0]     = bus_a.mul_b;
  assign in_ready_o[1]  = bus_b.in_ready;
  assign out_valid_o[1] = bus_b.out_valid;
  assign ovf_o[1]       = bus_b.ovf;
  assign q_o[1]         = bus_b.q;
  assign mul_a_o[1]     = bus_b.mul_a;
  assign mul_b_o[1]     = bus_b.mul_b;

  // ---------------- multiplier models ----------------
  // Latency 1: product visible combinationally. Latency 3: two register stages, so a
  // capture earlier than the third cycle would see a stale product.
  logic [63:0] prod_b, pb1, pb2;
  assign bus_a.mul_p = {32'b0, bus_a.mul_a} * {32'b0, bus_a.mul_b};
  assign prod_b      = {32'b0, bus_b.mul_a} * {32'b0, bus_b.mul_b};
  always @(posedge clk) begin
    pb1 <= prod_b;
    pb2 <= pb1;
  end
  assign bus_b.mul_p = pb2;

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Arithmetic model of one division: returns q and ovf, and the operand pairs in issue order.
  logic [31:0] mdl_a[$];
  logic [31:0] mdl_b[$];

  task automatic model_op(input int iter, input logic [31:0] n, input logic [31:0] d,
                          input logic [31:0] ia, output logic [31:0] q, output logic ovf);
    logic [31:0] nr, dr, k;
    logic [63:0] p;
    nr = n; dr = d; k = ia; ovf = 1'b0;
    mdl_a.delete();
    mdl_b.delete();
    for (int i = 0; i <= iter; i++) begin
      mdl_a.push_back(nr); mdl_b.push_back(k);
      p   = {32'b0, nr} * {32'b0, k};
      ovf = ovf | (p >= 64'h4000_0000_0000_0000);
      nr  = 32'(p >> 30);
      mdl_a.push_back(dr); mdl_b.push_back(k);
      p   = {32'b0, dr} * {32'b0, k};
      ovf = ovf | (p >= 64'h4000_0000_0000_0000);
      dr  = 32'(p >> 30);
      k   = 32'h8000_0000 - dr;
    end
    q = nr;
  endtask

  // ---------------- scoreboard ----------------
  logic [32:0] exp_q_a[$];
  logic [32:0] exp_q_b[$];

  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid_o[0]) begin
        if (exp_q_a.size() == 0) check("unexpected_out_valid_a", 64'(1), 64'(0));
        else begin
          check("q_a",   64'(q_o[0]),   64'(exp_q_a[0][31:0]));
          check("ovf_a", 64'(ovf_o[0]), 64'(exp_q_a[0][32]));
          if (out_ready_d[0]) void'(exp_q_a.pop_front());
        end
      end
      if (out_valid_o[1]) begin
        if (exp_q_b.size() == 0) check("unexpected_out_valid_b", 64'(1), 64'(0));
        else begin
          check("q_b",   64'(q_o[1]),   64'(exp_q_b[0][31:0]));
          check("ovf_b", 64'(ovf_o[1]), 64'(exp_q_b[0][32]));
          if (out_ready_d[1]) void'(exp_q_b.pop_front());
        end
      end
    end
  end

  // ---------------- driver ----------------
  // Starts #1 after an edge with the selected DUT idle; returns #1 after the edge that
  // hands the result off, with the DUT back in IDLE.
  task automatic run_op(input int sel, input logic [31:0] n, input logic [31:0] d,
                        input logic [31:0] ia, input int hold);
    int          iter, lat, total;
    logic [31:0] mq, lq, la, lb;
    logic        movf;
    iter = (sel == 0) ? 2 : 1;
    lat  = (sel == 0) ? 1 : 3;
    model_op(iter, n, d, ia, mq, movf);
    if (sel == 0) exp_q_a.push_back({movf, mq});
    else          exp_q_b.push_back({movf, mq});
    check("in_ready_before_accept", 64'(in_ready_o[sel]), 64'(1));
    n_d[sel] = n; d_d[sel] = d; ia_d[sel] = ia;
    in_valid_d[sel]  = 1'b1;
    out_ready_d[sel] = (hold == 0);
    @(posedge clk); #1;
    in_valid_d[sel] = 1'b0;
    total = 2 * (iter + 1) * lat;
    for (int c = 0; c < total; c++) begin
      check("busy_out_valid", 64'(out_valid_o[sel]), 64'(0));
      check("busy_in_ready",  64'(in_ready_o[sel]),  64'(0));
      check("mul_a_seq",      64'(mul_a_o[sel]),     64'(mdl_a[c / lat]));
      check("mul_b_seq",      64'(mul_b_o[sel]),     64'(mdl_b[c / lat]));
      @(posedge clk); #1;
    end
    check("latency_out_valid", 64'(out_valid_o[sel]), 64'(1));
    lq = q_o[sel];
    la = mdl_a[mdl_a.size() - 1];
    lb = mdl_b[mdl_b.size() - 1];
    for (int h = 0; h < hold; h++) begin
      in_valid_d[sel] = 1'b1;
      n_d[sel] = 32'h1234_5678; d_d[sel] = 32'h5555_0000; ia_d[sel] = 32'h2222_0000;
      check("stall_out_valid", 64'(out_valid_o[sel]), 64'(1));
      check("stall_in_ready",  64'(in_ready_o[sel]),  64'(0));
      check("stall_q_held",    64'(q_o[sel]),         64'(lq));
      check("stall_mul_a_held", 64'(mul_a_o[sel]),    64'(la));
      check("stall_mul_b_held", 64'(mul_b_o[sel]),    64'(lb));
      @(posedge clk); #1;
    end
    in_valid_d[sel]  = 1'b0;
    out_ready_d[sel] = 1'b1;
    @(posedge clk); #1;
    check("idle_out_valid", 64'(out_valid_o[sel]), 64'(0));
    check("idle_in_ready",  64'(in_ready_o[sel]),  64'(1));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] mq;
    logic        movf;
    int          diff;
    for (int s = 0; s < 2; s++) begin
      in_valid_d[s] = 1'b0; out_ready_d[s] = 1'b1;
      n_d[s] = '0; d_d[s] = '0; ia_d[s] = '0;
    end
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      check("rst_in_ready",  64'(in_ready_o[s]),  64'(1));
      check("rst_out_valid", 64'(out_valid_o[s]), 64'(0));
      check("rst_q",         64'(q_o[s]),         64'(0));
      check("rst_mul_a",     64'(mul_a_o[s]),     64'(0));
      check("rst_mul_b",     64'(mul_b_o[s]),     64'(0));
      check("rst_ovf",       64'(ovf_o[s]),       64'(0));
    end
    reset = 1'b0;
    @(posedge clk); #1;

    // Hand-computed pins on the model itself.
    model_op(2, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000, mq, movf);
    check("model_unity_q", 64'(mq), 64'(32'h4000_0000));
    check("model_unity_ovf", 64'(movf), 64'(0));
    model_op(2, 32'h4000_0000, 32'h6000_0000, 32'h2AAA_AAAA, mq, movf);
    diff = (mq > 32'h2AAA_AAAB) ? int'(mq - 32'h2AAA_AAAB) : int'(32'h2AAA_AAAB - mq);
    check("model_third_within_4lsb", 64'(diff <= 4), 64'(1));
    model_op(1, 32'h6000_0000, 32'h4000_0000, 32'h4000_0000, mq, movf);
    check("model_one_point_five_q", 64'(mq), 64'(32'h6000_0000));
    model_op(2, 32'hFFFF_FFFF, 32'h4000_0000, 32'h7FFF_FFFF, mq, movf);
    check("model_big_ovf", 64'(movf), 64'(1));

    // Unity, 1/1.5, and latency-3 cases.
    run_op(0, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 0);
    run_op(0, 32'h4000_0000, 32'h6000_0000, 32'h2AAA_AAAA, 0);
    run_op(1, 32'h6000_0000, 32'h4000_0000, 32'h4000_0000, 0);

    // Backpressure with ignored input, then back-to-back ops.
    run_op(0, 32'h4000_0000, 32'h6000_0000, 32'h2AAA_AAAA, 10);
    run_op(0, 32'h5000_0000, 32'h5000_0000, 32'h3333_3333, 0);
    run_op(1, 32'h4000_0000, 32'h6000_0000, 32'h2AAA_AAAA, 4);
    run_op(1, 32'h7000_0000, 32'h5800_0000, 32'h2E8B_A2E8, 0);

    // Overflow is flagged, then cleared by the next accept.
    run_op(0, 32'hFFFF_FFFF, 32'h4000_0000, 32'h7FFF_FFFF, 0);
    run_op(0, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 0);
    run_op(1, 32'hFFFF_FFFF, 32'h4000_0000, 32'h7FFF_FFFF, 0);

    // Reset in the second MUL_N of an overflowing op; nothing may come out for it.
    n_d[0] = 32'hFFFF_FFFF; d_d[0] = 32'h4000_0000; ia_d[0] = 32'h7FFF_FFFF;
    in_valid_d[0] = 1'b1;
    @(posedge clk); #1;
    in_valid_d[0] = 1'b0;
    @(posedge clk); #1;
    check("ovf_set_after_first_capture", 64'(ovf_o[0]), 64'(1));
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midop_rst_in_ready",  64'(in_ready_o[0]),  64'(1));
    check("midop_rst_out_valid", 64'(out_valid_o[0]), 64'(0));
    check("midop_rst_ovf",       64'(ovf_o[0]),       64'(0));
    check("midop_rst_mul_a",     64'(mul_a_o[0]),     64'(0));
    check("midop_rst_q",         64'(q_o[0]),         64'(0));
    repeat (8) @(posedge clk);
    #1;
    run_op(0, 32'h6000_0000, 32'h6000_0000, 32'h2AAA_AAAA, 0);
    run_op(1, 32'h5000_0000, 32'h5000_0000, 32'h3333_3333, 0);

    repeat (5) @(posedge clk);
    #1;
    check("queue_a_drained", 64'(exp_q_a.size()), 64'(0));
    check("queue_b_drained", 64'(exp_q_b.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
